mem_wb_stage: RTL

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data extraction.
// Tracks retired instructions and flags illegal load sizes.
module mem_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [63:0]      mem_result,
    input  logic             mem_to_reg,
    input  logic [3:0]       xfer_size,
    input  logic             load_signed,
    input  logic             reg_write,
    input  logic [4:0]       rd,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [4:0]       wb_rd,
    output logic [63:0]      wb_data,
    output logic [CNT_W-1:0] retired,
    output logic             size_err
);

    localparam logic [4:0] XZR = 5'd31;

    logic        sz_b;
    logic        sz_h;
    logic        sz_w;
    logic        sz_d;
    logic        illegal;
    logic        sx_b;
    logic        sx_h;
    logic        sx_w;
    logic [63:0] load_data;
    logic [63:0] cap_data;
    logic        cap_we;

    assign sz_b = (xfer_size == 4'd1);
    assign sz_h = (xfer_size == 4'd2);
    assign sz_w = (xfer_size == 4'd4);
    assign sz_d = (xfer_size == 4'd8);

    assign illegal = mem_to_reg & ~(sz_b | sz_h | sz_w | sz_d);

    assign sx_b = load_signed & mem_result[7];
    assign sx_h = load_signed & mem_result[15];
    assign sx_w = load_signed & mem_result[31];

    // Slice and extend raw read data according to the load width.
    always_comb begin
        load_data = '0;
        unique case (1'b1)
            sz_b:    load_data = {{56{sx_b}}, mem_result[7:0]};
            sz_h:    load_data = {{48{sx_h}}, mem_result[15:0]};
            sz_w:    load_data = {{32{sx_w}}, mem_result[31:0]};
            sz_d:    load_data = mem_result;
            default: load_data = '0;
        endcase
    end

    // Pick the value and write enable that a normal capture would latch.
    always_comb begin
        cap_data = mem_result;
        if (mem_to_reg) begin
            cap_data = illegal ? 64'd0 : load_data;
        end
        cap_we = mem_valid & reg_write & (rd != XZR) & ~illegal;
    end

    // WB register: reset beats flush beats stall beats capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= XZR;
            wb_data      <= '0;
            retired      <= '0;
            size_err     <= 1'b0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= XZR;
            wb_data      <= '0;
        end else if (!stall) begin
            wb_valid     <= mem_valid;
            wb_reg_write <= cap_we;
            wb_rd        <= rd;
            wb_data      <= cap_data;
            if (mem_valid) begin
                retired <= retired + CNT_W'(1);
            end
            if (mem_valid && illegal) begin
                size_err <= 1'b1;
            end
        end
    end

endmodule
